// File: rtl/spi_flash_ctrl.sv
// Register-mapped SPI NOR read engine (mode 0, single I/O, opcode 0x03).
// Define SPI_FLASH_FAST_READ_EN for opcode 0x0B with 8 dummy clocks before data.
module spi_flash_ctrl #(
    parameter int DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sel,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wd,
    output logic [15:0] rd,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    input  logic        spi_miso
);
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE    = 8'h0B;
    localparam bit         HAS_DUMMY = 1'b1;
`else
    localparam logic [7:0] OPCODE    = 8'h03;
    localparam bit         HAS_DUMMY = 1'b0;
`endif
    localparam logic [8:0] DIV_LAST = 9'(DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(2 * DIV - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [8:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        load;

    logic busy, pop, wr_ctrl, tick, bit_last;
    assign busy     = (state_q != IDLE);
    assign pop      = re && (sel == 2'd3);
    assign wr_ctrl  = we && (sel == 2'd2);
    assign tick     = (div_q == DIV_LAST);
    assign bit_last = (state_q == ADDR) ? (bit_q == 5'd23) : (bit_q == 5'd7);

    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = tx_q[31];

    always_comb begin
        case (sel)
            2'd0:    rd = addr_q[15:0];
            2'd1:    rd = {8'd0, addr_q[23:16]};
            2'd2:    rd = {count_q[13:0], valid_q, busy};
            default: rd = {8'd0, data_q};
        endcase
    end

    // NOTE: every *_d gets a default first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q && !pop;
        tx_d    = tx_q;
        rx_d    = rx_q;
        div_d   = tick ? 9'd0 : div_q + 9'd1;
        bit_d   = bit_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        load    = 1'b0;

        if (we && !busy && sel == 2'd0) addr_d[15:0]  = wd;
        if (we && !busy && sel == 2'd1) addr_d[23:16] = wd[7:0];

        case (state_q)
            IDLE: begin
                div_d = 9'd0;
                if (wr_ctrl && wd != 16'd0) begin
                    state_d = CMD;
                    count_d = wd;
                    tx_d    = {OPCODE, addr_q};
                    bit_d   = 5'd0;
                    sck_d   = 1'b0;
                    cs_n_d  = 1'b0;
                end
            end
            CMD, ADDR, DUMMY, DATA: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (state_q == DATA) rx_d = {rx_q[6:0], spi_miso};
                    end else begin
                        sck_d = 1'b0;
                        tx_d  = {tx_q[30:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                        if (bit_last) begin
                            bit_d = 5'd0;
                            case (state_q)
                                CMD:     state_d = ADDR;
                                ADDR:    state_d = HAS_DUMMY ? DUMMY : DATA;
                                DUMMY:   state_d = DATA;
                                default: begin
                                    // A full holding register stalls the bus with SCK low.
                                    if (valid_q && !pop) state_d = HOLD;
                                    else                 load    = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
            HOLD: begin
                div_d = 9'd0;
                if (pop) load = 1'b1;
            end
            GAP: begin
                div_d = div_q + 9'd1;
                if (div_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            data_d  = rx_q;
            valid_d = 1'b1;
            addr_d  = addr_q + 24'd1;
            count_d = count_q - 16'd1;
            div_d   = 9'd0;
            if (count_q == 16'd1) begin
                state_d = GAP;
                cs_n_d  = 1'b1;
            end else begin
                state_d = DATA;
            end
        end

        if (wr_ctrl && wd == 16'd0 && busy) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            valid_d = 1'b0;
            count_d = 16'd0;
            tx_d    = 32'd0;
            div_d   = 9'd0;
            bit_d   = 5'd0;
        end
    end

    // NOTE: the data and shift registers are reset too, since rd and MOSI expose them directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 24'd0;
            count_q <= 16'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            tx_q    <= 32'd0;
            rx_q    <= 8'd0;
            div_q   <= 9'd0;
            bit_q   <= 5'd0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Scoreboard bench for spi_flash_ctrl: flash model on the SPI pins, expected
// pops and command words queued by the stimulus and checked by monitors.
module tb_spi_flash_ctrl;
    localparam int DIV = 2;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         PREFIX = 40;
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam int         PREFIX = 32;
    localparam logic [7:0] OPCODE = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic        we, re;
    logic [15:0] wd, rd;
    logic        spi_sck, spi_mosi, spi_cs_n;
    logic        spi_miso = 1'b1;

    spi_flash_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .re(re), .wd(wd), .rd(rd),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [15:0] exp_pop_q[$];
    logic [39:0] exp_cmd_q[$];
    logic [7:0]  stream [4];
    int          rise_cnt = 0;

    // Pop monitor: every read strobe on the data register is checked against the queue.
    initial forever begin
        @(negedge clk);
        if (re && sel == 2'd3 && !reset) begin
            if (exp_pop_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h expected none", rd);
            end else begin
                check("pop_data", 40'(rd), 40'(exp_pop_q.pop_front()));
            end
        end
    end

    // Flash model: captures MOSI on SCK rise, shifts stream bytes out on SCK fall.
    initial begin
        logic [39:0] cap;
        logic [4:0]  idx;
        logic        sck_prev, cs_prev;
        cap = '0;
        sck_prev = 1'b0;
        cs_prev = 1'b1;
        forever begin
            @(spi_sck or spi_cs_n);
            if (!spi_cs_n && cs_prev) begin
                rise_cnt = 0;
                cap = '0;
                spi_miso = 1'b1;
            end
            if (!spi_cs_n && spi_sck && !sck_prev) begin
                rise_cnt++;
                cap = {cap[38:0], spi_mosi};
                if (rise_cnt == PREFIX) begin
                    if (exp_cmd_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL cmd_unexpected: got 0x%0h expected none", cap);
                    end else begin
                        check("cmd_addr_mosi", cap, exp_cmd_q.pop_front());
                    end
                end
            end
            if (!spi_cs_n && !spi_sck && sck_prev && rise_cnt >= PREFIX) begin
                if (rise_cnt - PREFIX < 32) begin
                    idx = 5'(rise_cnt - PREFIX);
                    spi_miso = stream[idx[4:3]][3'd7 - idx[2:0]];
                end else begin
                    spi_miso = 1'b1;
                end
            end
            sck_prev = spi_sck;
            cs_prev = spi_cs_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [15:0] d);
        sel = s;
        wd = d;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic pop();
        sel = 2'd3;
        re = 1'b1;
        step();
        re = 1'b0;
    endtask

    task automatic rdreg(input logic [1:0] s, output logic [15:0] v);
        sel = s;
        #1;
        v = rd;
    endtask

    task automatic wait_stat(input int b, input logic v, input string name);
        logic [15:0] s;
        for (int i = 0; i < 2000; i++) begin
            rdreg(2'd2, s);
            if (s[b] == v) return;
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout, status bit %0d never reached %0b", name, b, v);
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 2000; i++) begin
            if (rise_cnt >= n) return;
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_rises: got %0d SCK rises expected %0d", rise_cnt, n);
    endtask

    task automatic start_read(input logic [23:0] a, input logic [15:0] n, input bit expect_cmd);
        logic [39:0] e;
        e = {OPCODE, a, 8'h00};
        e = e >> (40 - PREFIX);
        if (expect_cmd) exp_cmd_q.push_back(e);
        wr(2'd0, a[15:0]);
        wr(2'd1, {8'd0, a[23:16]});
        wr(2'd2, n);
    endtask

    initial begin
        logic [15:0] v;
        int t0, tv, bad;
        // First byte completes after the prefix bits plus its own 8 bits, with start/capture slack.
        int bound;
        bound = 1 + (PREFIX + 8) * 2 * DIV + 2;
        reset = 1'b1;
        sel = 2'd0;
        we = 1'b0;
        re = 1'b0;
        wd = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pins", 40'({spi_cs_n, spi_sck, spi_mosi}), 40'(3'b100));
        rdreg(2'd2, v); check("reset_status", 40'(v), 40'h0);
        rdreg(2'd0, v); check("reset_addr_lo", 40'(v), 40'h0);
        rdreg(2'd3, v); check("reset_data", 40'(v), 40'h0);
        reset = 1'b0;
        step();

        // Basic read
        stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'h00; stream[3] = 8'h00;
        exp_pop_q.push_back(16'h00A5);
        exp_pop_q.push_back(16'h003C);
        start_read(24'h012345, 16'd2, 1'b1);
        t0 = cyc;
        check("cs_low_after_start", 40'(spi_cs_n), 40'h0);
        rdreg(2'd2, v); check("status_started", 40'(v), 40'h0009);
        wait_stat(1, 1'b1, "basic_byte0");
        check("first_byte_latency_ok", 40'((cyc - t0) <= bound), 40'h1);
        pop();
        wait_stat(1, 1'b1, "basic_byte1");
        tv = cyc;
        check("cs_high_after_last", 40'(spi_cs_n), 40'h1);
        wait_stat(0, 1'b0, "basic_idle");
        check("gap_cycles", 40'(cyc - tv), 40'(2 * DIV));
        pop();
        rdreg(2'd0, v); check("basic_addr_lo", 40'(v), 40'h2347);
        rdreg(2'd1, v); check("basic_addr_hi", 40'(v), 40'h0001);
        rdreg(2'd2, v); check("basic_status_end", 40'(v), 40'h0);
        check("basic_sck_rises", 40'(rise_cnt), 40'(PREFIX + 16));
        exp_pop_q.push_back(16'h003C);
        pop();
        rdreg(2'd2, v); check("stale_pop_no_change", 40'(v), 40'h0);

        // Backpressure
        stream[0] = 8'h5A; stream[1] = 8'hC3; stream[2] = 8'h7E;
        exp_pop_q.push_back(16'h005A);
        exp_pop_q.push_back(16'h00C3);
        exp_pop_q.push_back(16'h007E);
        start_read(24'h000400, 16'd3, 1'b1);
        wait_stat(1, 1'b1, "bp_byte0");
        repeat (50) step();
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            if (spi_sck !== 1'b0 || spi_cs_n !== 1'b0) bad++;
            step();
        end
        check("hold_sck_low_cs_low", 40'(bad), 40'h0);
        rdreg(2'd2, v); check("hold_status", 40'(v), 40'h000B);
        rdreg(2'd0, v); check("hold_addr_lo", 40'(v), 40'h0401);
        pop();
        rdreg(2'd2, v); check("hold_pop_reload", 40'(v), 40'h0007);
        pop();
        wait_stat(1, 1'b1, "bp_byte2");
        pop();
        wait_stat(0, 1'b0, "bp_idle");
        rdreg(2'd0, v); check("bp_addr_lo", 40'(v), 40'h0403);

        // Abort during ADDR, then a fresh transfer
        start_read(24'h000100, 16'd4, 1'b0);
        wait_rises(12);
        wr(2'd2, 16'd0);
        check("abort_pins", 40'({spi_cs_n, spi_sck}), 40'(2'b10));
        rdreg(2'd2, v); check("abort_status", 40'(v), 40'h0);
        rdreg(2'd0, v); check("abort_addr_lo", 40'(v), 40'h0100);
        step();
        stream[0] = 8'h96;
        exp_pop_q.push_back(16'h0096);
        start_read(24'h000200, 16'd1, 1'b1);
        wait_stat(1, 1'b1, "restart_byte0");
        pop();
        wait_stat(0, 1'b0, "restart_idle");
        rdreg(2'd0, v); check("restart_addr_lo", 40'(v), 40'h0201);

        // Address wrap
        stream[0] = 8'hF0; stream[1] = 8'h0F;
        exp_pop_q.push_back(16'h00F0);
        exp_pop_q.push_back(16'h000F);
        start_read(24'hFFFFFF, 16'd2, 1'b1);
        wait_stat(1, 1'b1, "wrap_byte0");
        pop();
        wait_stat(1, 1'b1, "wrap_byte1");
        pop();
        wait_stat(0, 1'b0, "wrap_idle");
        rdreg(2'd0, v); check("wrap_addr_lo", 40'(v), 40'h0001);
        rdreg(2'd1, v); check("wrap_addr_hi", 40'(v), 40'h0000);

        // Asynchronous reset in the middle of the second data byte
        stream[0] = 8'h11; stream[1] = 8'h22;
        start_read(24'h000800, 16'd2, 1'b1);
        wait_stat(1, 1'b1, "rst_byte0");
        wait_rises(PREFIX + 10);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pins", 40'({spi_cs_n, spi_sck, spi_mosi}), 40'(3'b100));
        rdreg(2'd2, v); check("async_rst_status", 40'(v), 40'h0);
        rdreg(2'd3, v); check("async_rst_data", 40'(v), 40'h0);
        #1;
        reset = 1'b0;
        repeat (20) step();
        rdreg(2'd2, v); check("post_rst_no_partial", 40'(v), 40'h0);

        check("pop_queue_drained", 40'(exp_pop_q.size()), 40'h0);
        check("cmd_queue_drained", 40'(exp_cmd_q.size()), 40'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
